// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//
// Output reordering buffer at the tail of the R2MDC FFT pipeline. The last
// butterfly stage delivers two parallel streams (Y0 on in0, Y1 on in1) in
// bit-reversed bin order; this block collects a full frame into one bank of
// a ping-pong buffer and replays it in natural bin order, one complex sample
// per cycle, while the other bank is being filled.
//
// Parameters
//   N   FFT size, power of two, 4..256
//   DW  component width (signed Q8.8), passed through bit-exact
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 synchronous active-low reset
//   in_valid / in_ready   input pair handshake
//   in0_re, in0_im        butterfly Y0 output (bin b0 = bitrev(pair))
//   in1_re, in1_im        butterfly Y1 output (bin b0 + N/2)
//   out_valid / out_ready output sample handshake
//   out_re, out_im        natural-order bin value (0 when !out_valid)
//   out_idx               bin index of current output (0 when !out_valid)
//   out_last              high with bin N-1

module fft_out_reorder #(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in0_re,
  input  logic [DW-1:0]        in0_im,
  input  logic [DW-1:0]        in1_re,
  input  logic [DW-1:0]        in1_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last
);

  localparam int addr_w = $clog2(N);
  localparam int pair_w = addr_w - 1;

  localparam logic [pair_w-1:0] pair_last = pair_w'(N / 2 - 1);
  localparam logic [addr_w-1:0] bin_last  = addr_w'(N - 1);

  typedef enum logic [1:0] {
    bank_empty,
    bank_filling,
    bank_full,
    bank_draining
  } bank_state_t;

  bank_state_t         bank_state [2];
  logic                wr_bank;
  logic                rd_bank;
  logic [pair_w-1:0]   wr_cnt;
  logic [addr_w-1:0]   rd_cnt;

  logic [2*DW-1:0]     mem [2*N];

  logic [1:0]          full;
  logic                wr_fire;
  logic                rd_fire;
  logic [pair_w-1:0]   pair_rev;
  logic [2*DW-1:0]     rd_word;

  // Bit reversal over log2(N)-1 bits maps the pair counter to the bin
  // carried on in0; the in1 bin is the same address with the MSB set.
  function automatic logic [pair_w-1:0] bit_reverse(input logic [pair_w-1:0] v);
    logic [pair_w-1:0] r;
    r = '0;
    for (int i = 0; i < pair_w; i++) begin
      r[i] = v[pair_w-1-i];
    end
    return r;
  endfunction

  // A bank counts as full from the moment its last pair lands until its
  // last sample leaves, i.e. in both the FULL and DRAINING states.
  always_comb begin
    full = '0;
    for (int i = 0; i < 2; i++) begin
      full[i] = (bank_state[i] == bank_full) || (bank_state[i] == bank_draining);
    end
  end

  // Handshakes are decoded from registered state only, so a drain that
  // completes this cycle cannot open in_ready until the next one.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign pair_rev  = bit_reverse(wr_cnt);
  assign rd_word   = mem[{rd_bank, rd_cnt}];

  // Output fields are forced to zero whenever nothing valid is presented.
  assign out_re   = out_valid ? rd_word[2*DW-1:DW] : '0;
  assign out_im   = out_valid ? rd_word[DW-1:0]    : '0;
  assign out_idx  = out_valid ? rd_cnt             : '0;
  assign out_last = out_valid && (rd_cnt == bin_last);

  // Sample storage. Each accepted pair writes two words into the current
  // write bank at their natural-order addresses; contents are not reset
  // because the full flags alone decide what is ever read out.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, 1'b0, pair_rev}] <= {in0_re, in0_im};
      mem[{wr_bank, 1'b1, pair_rev}] <= {in1_re, in1_im};
    end
  end

  // Per-bank lifecycle plus write/read pointers. A write can only target a
  // bank that is not full and a read only a bank that is, so when both fire
  // in the same cycle they always touch different banks and both updates
  // take effect together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_state[0] <= bank_empty;
      bank_state[1] <= bank_empty;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == pair_last) begin
          bank_state[wr_bank] <= bank_full;
          wr_bank             <= !wr_bank;
          wr_cnt              <= '0;
        end else begin
          bank_state[wr_bank] <= bank_filling;
          wr_cnt              <= wr_cnt + pair_w'(1);
        end
      end
      if (rd_fire) begin
        if (rd_cnt == bin_last) begin
          bank_state[rd_bank] <= bank_empty;
          rd_bank             <= !rd_bank;
          rd_cnt              <= '0;
        end else begin
          bank_state[rd_bank] <= bank_draining;
          rd_cnt              <= rd_cnt + addr_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder
//
// Self-checking bench for fft_out_reorder with N=16, DW=16. Frames are held
// as bin-indexed arrays; the bench feeds them in bit-reversed pair order and
// expects the bins back in natural order.

module tb_fft_out_reorder;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in0_re = '0;
  logic [DW-1:0] in0_im = '0;
  logic [DW-1:0] in1_re = '0;
  logic [DW-1:0] in1_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [3:0]    out_idx;
  logic          out_last;

  logic [37:0]   obs;
  logic [31:0]   fr [4][16];

  int checks   = 0;
  int failures = 0;

  localparam logic [37:0] idle_vec = '0;

  fft_out_reorder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0_re    (in0_re),
    .in0_im    (in0_im),
    .in1_re    (in1_re),
    .in1_im    (in1_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Everything the output port shows, packed for one-shot comparison.
  assign obs = {out_valid, out_last, out_idx, out_re, out_im};

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reverse the three bits of a pair number to get its in0 bin.
  function automatic int brev(input int p);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      if (((p >> i) & 1) != 0) r += (1 << (2 - i));
    end
    return r;
  endfunction

  // Expected output vector when bin b of frame f is being presented.
  function automatic logic [37:0] expv(input int f, input int b);
    return {1'b1, (b == N - 1), 4'(b), fr[f][b]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive pair p of frame f onto both input lanes.
  task automatic applyStimulus(input int f, input int p);
    int b0;
    b0 = brev(p);
    {in0_re, in0_im} = fr[f][b0];
    {in1_re, in1_im} = fr[f][b0 + N / 2];
  endtask

  task automatic fill_random(input int f);
    for (int b = 0; b < N; b++) fr[f][b] = $urandom;
  endtask

  // Reset state after a clean reset.
  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    checks++;
    if (obs !== idle_vec) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h required=%h", obs, idle_vec);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready);
    end
  endtask

  // One frame with re = 16*bin, im = -bin, out_ready high throughout.
  task automatic test_single_frame;
    for (int b = 0; b < N; b++) fr[0][b] = {16'(16 * b), 16'(-b)};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      applyStimulus(0, p);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sf_fill[%0d] got in_ready=%b out_valid=%b required 1/0", p, in_ready, out_valid);
      end
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs !== expv(0, i)) begin
        failures++;
        $display("[TB] FAIL sf_out[%0d] got=%h required=%h", i, obs, expv(0, i));
      end
      tick;
    end
    checks++;
    if (obs !== idle_vec) begin
      failures++;
      $display("[TB] FAIL sf_idle got=%h required=%h", obs, idle_vec);
    end
  endtask

  // Real butterfly values in pair 0 only, everything else zero.
  task automatic test_butterfly_values;
    for (int b = 0; b < N; b++) fr[0][b] = '0;
    fr[0][0] = {16'hFC7C, 16'hFC41};
    fr[0][8] = {16'h0290, 16'hFF51};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      applyStimulus(0, p);
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs !== expv(0, i)) begin
        failures++;
        $display("[TB] FAIL bf_out[%0d] got=%h required=%h", i, obs, expv(0, i));
      end
      tick;
    end
  endtask

  // Three idle input cycles after pair 4; output must wait for pair 7.
  task automatic test_input_gaps;
    fill_random(0);
    out_ready = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      in_valid = 1'b1;
      applyStimulus(0, p);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL gap_fill[%0d] got in_ready=%b out_valid=%b required 1/0", p, in_ready, out_valid);
      end
      tick;
      if (p == 4) begin
        in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gap_hold[%0d] got out_valid=%b required 0", g, out_valid);
          end
          tick;
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs !== expv(0, i)) begin
        failures++;
        $display("[TB] FAIL gap_out[%0d] got=%h required=%h", i, obs, expv(0, i));
      end
      tick;
    end
  endtask

  // Two frames with in_valid held high and out_ready tied high. Expected
  // timeline: frame 1 fills in cycles 0..7 and drains 8..23, frame 2 fills
  // 8..15 and drains 24..39; in_ready is low from 16 through 23.
  task automatic test_back_to_back;
    int     sent;
    logic   acc;
    logic   exp_rdy;
    logic [37:0] exp_o;
    fill_random(0);
    fill_random(1);
    out_ready = 1'b1;
    sent = 0;
    for (int t = 0; t < 42; t++) begin
      if (sent < N) begin
        in_valid = 1'b1;
        applyStimulus(sent / 8, sent % 8);
      end else begin
        in_valid = 1'b0;
      end
      exp_rdy = (t < 16) || (t >= 24);
      if (t < 8)       exp_o = idle_vec;
      else if (t < 24) exp_o = expv(0, t - 8);
      else if (t < 40) exp_o = expv(1, t - 24);
      else             exp_o = idle_vec;
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL b2b_ready[t=%0d] got=%b required=%b", t, in_ready, exp_rdy);
      end
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("[TB] FAIL b2b_out[t=%0d] got=%h required=%h", t, obs, exp_o);
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) sent++;
    end
    in_valid = 1'b0;
  endtask

  // out_ready pattern 1,0,0,1 repeating during the drain.
  task automatic test_backpressure;
    int          idx;
    logic        prev_stall;
    logic [37:0] prev_obs;
    fill_random(0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      applyStimulus(0, p);
      tick;
    end
    in_valid = 1'b0;
    idx = 0;
    prev_stall = 1'b0;
    prev_obs = '0;
    for (int k = 0; k < 100 && idx < N; k++) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      checks++;
      if (obs !== expv(0, idx)) begin
        failures++;
        $display("[TB] FAIL bp_out[k=%0d] got=%h required=%h", k, obs, expv(0, idx));
      end
      if (prev_stall) begin
        checks++;
        if (obs !== prev_obs) begin
          failures++;
          $display("[TB] FAIL bp_stable[k=%0d] got=%h required=%h", k, obs, prev_obs);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
      if (out_valid && out_ready) idx++;
      tick;
    end
    out_ready = 1'b1;
    checks++;
    if (idx != N || obs !== idle_vec) begin
      failures++;
      $display("[TB] FAIL bp_done got idx=%0d out=%h required idx=16 out=%h", idx, obs, idle_vec);
    end
  endtask

  // Reset while bin 5 is presented and a second frame is partly written.
  task automatic test_reset_mid_drain;
    fill_random(0);
    fill_random(1);
    fill_random(2);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      applyStimulus(0, p);
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, i);
      checks++;
      if (obs !== expv(0, i)) begin
        failures++;
        $display("[TB] FAIL rmd_pre[%0d] got=%h required=%h", i, obs, expv(0, i));
      end
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (obs !== expv(0, 5)) begin
      failures++;
      $display("[TB] FAIL rmd_idx5 got=%h required=%h", obs, expv(0, 5));
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if (obs !== idle_vec || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rmd_reset got out=%h in_ready=%b required out=%h in_ready=1", obs, in_ready, idle_vec);
    end
    tick;
    checks++;
    if (obs !== idle_vec) begin
      failures++;
      $display("[TB] FAIL rmd_discard got=%h required=%h", obs, idle_vec);
    end
    in_valid = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      applyStimulus(2, p);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rmd_fill[%0d] got out_valid=%b required 0", p, out_valid);
      end
      tick;
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs !== expv(2, i)) begin
        failures++;
        $display("[TB] FAIL rmd_out[%0d] got=%h required=%h", i, obs, expv(2, i));
      end
      tick;
    end
  endtask

  // Four random frames with random in_valid and out_ready. The reference is
  // a queue of {bin, value} entries appended once a frame is fully accepted;
  // the head is what must be on the output, and two completed frames still
  // held means the writer must be blocked.
  task automatic test_random_stream;
    int          sent;
    logic [35:0] q [$];
    logic        prev_stall;
    logic [37:0] prev_obs;
    logic [37:0] exp_o;
    logic        exp_rdy;
    logic        acc;
    logic        xfer;
    for (int f = 0; f < 4; f++) fill_random(f);
    sent = 0;
    prev_stall = 1'b0;
    prev_obs = '0;
    for (int k = 0; k < 3000 && (sent < 32 || q.size() > 0); k++) begin
      in_valid = (sent < 32) && ($urandom_range(3) != 0);
      if (sent < 32) applyStimulus(sent / 8, sent % 8);
      out_ready = ($urandom_range(2) != 0);
      exp_rdy = ((q.size() + 15) / 16) < 2;
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL rs_ready[k=%0d] got=%b required=%b", k, in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (obs !== prev_obs) begin
          failures++;
          $display("[TB] FAIL rs_stable[k=%0d] got=%h required=%h", k, obs, prev_obs);
        end
      end
      if (q.size() > 0) exp_o = {1'b1, (q[0][35:32] == 4'd15), q[0]};
      else              exp_o = idle_vec;
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("[TB] FAIL rs_out[k=%0d] got=%h required=%h", k, obs, exp_o);
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      tick;
      if (xfer && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        sent++;
        if (sent % 8 == 0) begin
          for (int b = 0; b < N; b++) q.push_back({4'(b), fr[sent / 8 - 1][b]});
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 32 || q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rs_complete got sent=%0d pending=%0d required sent=32 pending=0", sent, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_butterfly_values;
    test_input_gaps;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_drain;
    test_random_stream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reordering buffer at the tail of the R2MDC FFT pipeline. It accepts the final butterfly stage's two parallel output streams, Y0 and Y1, which arrive in bit-reversed bin order. It emits one complex sample per cycle in natural bin order (X(0)…X(N-1)) on a valid/ready stream. A two-bank ping-pong buffer lets one frame be written while the previous frame drains.

## Interface
- N, 16: FFT size; power of two, 4 ≤ N ≤ 256.
- DW, 16: component width; signed Q8.8 (8 fractional bits), same format as the butterfly.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset is synchronous and active-low.
- in_valid  in  1  input pair valid.
- in_ready  out  1  buffer can accept a pair.
- in0_re, in0_im  in  DW each  butterfly Y0 output.
- in1_re, in1_im  in  DW each  butterfly Y1 output.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_re, out_im  out  DW each  natural-order bin value.
- out_idx  out  log2(N)  bin index of current output.
- out_last  out  1  high with bin N-1.

## Operation
- Storage:
  - Two banks (A, B), each N complex words.
  - Per-bank full flag.
  - Write bank pointer wr_bank and pair counter wr_cnt (0..N/2-1).
  - Read bank pointer rd_bank and sample counter rd_cnt (0..N-1).
- Input order:
  - Pair p of a frame carries bins b0 = bitrev_{log2N-1}(p) on in0 and b1 = b0 + N/2 on in1.
  - For N=16, p=0..7 gives in0 bins 0,4,2,6,1,5,3,7 and in1 bins 8,12,10,14,9,13,11,15.
- Write:
  - Accept when in_valid && in_ready.
  - Store in0 at bank[wr_bank][b0] and in1 at bank[wr_bank][b1]; increment wr_cnt.
  - On the accept with wr_cnt = N/2-1: set full[wr_bank], toggle wr_bank, wr_cnt ← 0.
- in_ready = !full[wr_bank], decoded from registered flags only.
- Read:
  - out_valid = full[rd_bank].
  - out_re/out_im = bank[rd_bank][rd_cnt]; out_idx = rd_cnt; out_last = out_valid && rd_cnt = N-1.
  - When !out_valid, out_re, out_im, out_idx and out_last are driven to 0.
  - Advance rd_cnt on out_valid && out_ready.
  - On the transfer with rd_cnt = N-1: clear full[rd_bank], toggle rd_bank, rd_cnt ← 0.
- Data passes through bit-exact; no arithmetic, rounding or saturation.
- Per-bank state: EMPTY → FILLING (first pair accepted) → FULL (last pair) → DRAINING (first output accepted) → EMPTY (out_last accepted).
- Boundary conditions:
  - In the cycle the drain of bank X completes while the writer waits on X, in_ready stays 0. It rises the next cycle; there is no combinational ready path.
  - If the fill of bank Y completes in the same cycle that bank X finishes draining, both flag updates take effect. out_valid then stays high with no bubble on the next cycle, showing Y's bin 0.
  - Holding in_valid low mid-frame pauses the fill; partial frames are retained indefinitely.
  - out_ready low holds all output signals stable.

## Timing
- Reset (rst_n low at an edge):
  - All full flags are cleared; wr_bank, rd_bank, wr_cnt and rd_cnt ← 0.
  - Next cycle: in_ready = 1, out_valid = 0, out_re, out_im, out_idx and out_last = 0.
  - Bank contents are don't-care.
  - Reset mid-frame discards both banks, including a partially drained frame.
- Latency: bin 0 of a frame is presented on out_valid one cycle after the edge that accepts its final pair.
- Throughput:
  - Input accepts one pair per cycle up to N/2 pairs per bank.
  - Sustained rate is one pair per 2 cycles, limited by the output rate of one sample per cycle.
  - With out_ready tied high and continuous input, the pattern is steady state after the second frame.

## Test plan
- Single frame, N=16, out_ready=1:
  - Stimulus: pair p with in0 = {re=16·b0, im=-b0} and in1 = {re=16·b1, im=-b1}.
  - Required: out_valid rises one cycle after the 8th accept.
  - Required: 16 consecutive outputs with out_idx 0..15, out_re = 16·idx and out_im = -idx; out_last only at idx 15.
- Butterfly values:
  - Stimulus: pair 0 with in0 = (-900, -959) = 0xFC7C, 0xFC41 and in1 = (0x0290, 0xFF51); other pairs zero.
  - Required: bin 0 = 0xFC7C/0xFC41, bin 8 = 0x0290/0xFF51, all other bins 0.
- Back-to-back frames, out_ready=1, in_valid held high:
  - Required: frame 2 is accepted in 8 cycles into bank B.
  - Required: in_ready is then low until the cycle after frame 1's out_last.
  - Required: frame 2 bin 0 follows frame 1 bin 15 with no gap.
- Output backpressure:
  - Stimulus: toggle out_ready 1,0,0,1… during the drain.
  - Required: out_* stay stable while stalled; the sequence is still 0..15 with no loss or duplicates.
- Input gaps:
  - Stimulus: in_valid low for 3 cycles after pair 4.
  - Required: no output until pair 7 is accepted; the result matches the single-frame case.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 at out_idx=5 for one cycle.
  - Required: the next cycle shows out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0 and in_ready=1.
  - Required: a fresh frame then drains correctly from bin 0.
